// File: rtl/booth_r4_seq_mult.sv
// -----------------------------------------------------------------------------
// booth_r4_seq_mult
//
// Sequential signed 16x16 radix-4 Booth multiplier. Operands are accepted over
// a valid/ready handshake, one Booth partial-product row is formed and added
// to a 32-bit accumulator per clock, and the product is offered over a second
// valid/ready handshake. The accumulator register drives the product output.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operands valid
//   in_ready   block can accept operands (high in IDLE)
//   a          multiplicand, two's complement
//   b          multiplier, two's complement (Booth-recoded internally)
//   out_valid  product valid (high in DONE)
//   out_ready  downstream accepts the product
//   p          product, two's complement (accumulator register)
//   busy       high in RUN
//
// Configuration macro:
//   APPROX_ROW0_SKIP_EN  when defined, Booth row 0 is never added; RUN lasts
//                        7 cycles and p = a*b - d0*a (approximate mode).
//                        When undefined, the product is exact (8-cycle RUN).
// -----------------------------------------------------------------------------
module booth_r4_seq_mult #(
  parameter int ROWS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] p,
  output logic        busy
);

  localparam int CW = $clog2(ROWS);
  localparam logic [CW-1:0] LAST_ROW = CW'(ROWS - 1);

`ifdef APPROX_ROW0_SKIP_EN
  // Row 0 is skipped entirely: RUN begins on row 1.
  localparam logic [CW-1:0] FIRST_ROW = CW'(1);
`else
  localparam logic [CW-1:0] FIRST_ROW = CW'(0);
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [31:0]     acc_q,   acc_d;
  logic [15:0]     a_q,     a_d;
  logic [15:0]     b_q,     b_d;

  // ---------------------------------------------------------------------------
  // Booth row generation for the current digit index cnt_q.
  // ---------------------------------------------------------------------------
  logic [16:0]     b_ext;      // b with the implicit b[-1] = 0 appended
  logic [CW:0]     shamt;      // 2*i, both the triplet base and the row weight
  logic [2:0]      trip;       // {b[2i+1], b[2i], b[2i-1]}
  logic            row_zero;
  logic            row_neg;
  logic            row_two;
  logic [17:0]     a_ext;
  logic [17:0]     mag;
  logic [17:0]     row;
  logic [31:0]     addend;

  assign b_ext = {b_q, 1'b0};
  assign shamt = {cnt_q, 1'b0};
  assign trip  = b_ext[shamt +: 3];
  assign a_ext = {{2{a_q[15]}}, a_q};

  always_comb begin
    // NOTE: every variable written in a combinational block gets a default
    // first, so no path through the case leaves it unassigned (no latch).
    row_zero = 1'b0;
    row_neg  = 1'b0;
    row_two  = 1'b0;
    unique case (trip)
      3'b000, 3'b111: row_zero = 1'b1;
      3'b001, 3'b010: ;                                  // +1
      3'b011:         row_two  = 1'b1;                   // +2
      3'b100:         begin row_neg = 1'b1; row_two = 1'b1; end  // -2
      3'b101, 3'b110: row_neg  = 1'b1;                   // -1
      default:        row_zero = 1'b1;
    endcase
  end

  // 18 bits hold +-2*a for every 16-bit a, including 2*(-32768) negated.
  assign mag    = row_two ? {a_ext[16:0], 1'b0} : a_ext;
  assign row    = row_zero ? 18'd0 : (row_neg ? (~mag + 18'd1) : mag);
  assign addend = {{14{row[17]}}, row} << shamt;

  // ---------------------------------------------------------------------------
  // Control FSM: next state and datapath updates.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b;
          acc_d   = 32'd0;
          cnt_d   = FIRST_ROW;
        end
      end
      RUN: begin
        acc_d = acc_q + addend;        // modulo 2^32
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_ROW) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= 32'd0;
      a_q     <= 16'd0;
      b_q     <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  // All outputs are decoded from registers only.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN);
  assign p         = acc_q;

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// -----------------------------------------------------------------------------
// Self-checking bench for booth_r4_seq_mult. A transaction-level model tracks
// accept, latency and output handshake and predicts every output; a negedge
// compare process checks the DUT against it each cycle. Directed cases pin the
// model with hand-computed products; a random phase exercises backpressure and
// ignored in_valid pulses.
// -----------------------------------------------------------------------------
module tb_booth_r4_seq_mult;

`ifdef APPROX_ROW0_SKIP_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 8;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] p;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  booth_r4_seq_mult dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Reference product from plain signed arithmetic.
  function automatic logic [31:0] ref_prod(input logic [15:0] aa, input logic [15:0] bb);
    longint pa, pb, prod;
    pa   = longint'($signed(aa));
    pb   = longint'($signed(bb));
    prod = pa * pb;
`ifdef APPROX_ROW0_SKIP_EN
    prod = prod - (longint'(-2) * longint'(bb[1]) + longint'(bb[0])) * pa;
`endif
    return prod[31:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Transaction-level model.
  // ---------------------------------------------------------------------------
  bit          m_init = 1'b0;
  int          m_left = 0;     // RUN cycles still to go
  bit          m_done = 1'b0;
  logic [31:0] m_exp  = '0;
  logic [31:0] m_p    = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_init <= 1'b1;
      m_left <= 0;
      m_done <= 1'b0;
      m_p    <= 32'd0;
    end else if (m_init) begin
      if (m_left == 0 && !m_done) begin
        if (in_valid) begin
          m_left <= LAT;
          m_exp  <= ref_prod(a, b);
        end
      end else if (m_left > 0) begin
        if (m_left == 1) begin
          m_done <= 1'b1;
          m_p    <= m_exp;
        end
        m_left <= m_left - 1;
      end else if (m_done && out_ready) begin
        m_done <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init && rst_n) begin
      check("in_ready",  {31'd0, in_ready},  {31'd0, (m_left == 0 && !m_done)});
      check("out_valid", {31'd0, out_valid}, {31'd0, m_done});
      check("busy",      {31'd0, busy},      {31'd0, (m_left > 0)});
      if (m_left == 0) check("p", p, m_p);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers; all called at #1 after a rising edge.
  // ---------------------------------------------------------------------------
  task automatic issue(input logic [15:0] aa, input logic [15:0] bb);
    int guard = 0;
    while (in_ready !== 1'b1 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 100) fail_now("issue_wait");
    a        = aa;
    b        = bb;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input bit noise, output int cycles);
    cycles = 0;
    while (out_valid !== 1'b1 && cycles < 50) begin
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        a        = 16'($urandom);
        b        = 16'($urandom);
      end
      @(posedge clk); #1;
      cycles++;
    end
    in_valid = 1'b0;
    if (cycles >= 50) fail_now("out_wait");
  endtask

  task automatic run_op(input string name, input logic [15:0] aa, input logic [15:0] bb,
                        input logic [31:0] exp);
    int lat;
    out_ready = 1'b1;
    issue(aa, bb);
    wait_out(1'b0, lat);
    check({name, "_lat"}, 32'(lat), 32'(LAT));
    check(name, p, exp);
    @(posedge clk); #1;
    check({name, "_in_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  // Expected literals for each build.
`ifdef APPROX_ROW0_SKIP_EN
  localparam logic [31:0] E_3X5    = 32'h0000_000C;
  localparam logic [31:0] E_MINMIN = 32'h4000_0000;
  localparam logic [31:0] E_NEG1   = 32'h0000_0000;
  localparam logic [31:0] E_1234   = 32'hFFF5_4E10;
  localparam logic [31:0] E_7X6    = 32'd56;
  localparam logic [31:0] E_100X3  = 32'd400;
  localparam logic [31:0] E_100X4  = 32'd400;
`else
  localparam logic [31:0] E_3X5    = 32'h0000_000F;
  localparam logic [31:0] E_MINMIN = 32'h4000_0000;
  localparam logic [31:0] E_NEG1   = 32'hFFFF_FFFF;
  localparam logic [31:0] E_1234   = 32'hFFF5_52E2;
  localparam logic [31:0] E_7X6    = 32'd42;
  localparam logic [31:0] E_100X3  = 32'd300;
  localparam logic [31:0] E_100X4  = 32'd400;
`endif

  initial begin
    int lat;
    int guard;
    logic [15:0] ra, rb;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = 16'd0;
    b         = 16'd0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    check("rst_p",         p,                  32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);

    // Pin the model against hand-computed products.
    check("pin_3x5",    ref_prod(16'd3, 16'd5),           E_3X5);
    check("pin_minmin", ref_prod(16'h8000, 16'h8000),     E_MINMIN);
    check("pin_1234",   ref_prod(16'd1234, 16'hFDC9),     E_1234);
    check("pin_100x3",  ref_prod(16'd100, 16'd3),         E_100X3);

    run_op("p_3x5",    16'd3,    16'd5,    E_3X5);
    run_op("p_minmin", 16'h8000, 16'h8000, E_MINMIN);
    run_op("p_neg1",   16'hFFFF, 16'h0001, E_NEG1);
    run_op("p_100x3",  16'd100,  16'd3,    E_100X3);
    run_op("p_100x4",  16'd100,  16'd4,    E_100X4);

    // Backpressure: product held, in_ready low, stray in_valid ignored.
    out_ready = 1'b0;
    issue(16'd1234, 16'hFDC9);
    wait_out(1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      check("stall_p",         p,                  E_1234);
      check("stall_in_ready",  {31'd0, in_ready},  32'd0);
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
      if (i == 2) begin
        a        = 16'd1;
        b        = 16'd1;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("stall_after_p",         p,                  E_1234);
    check("stall_after_in_ready",  {31'd0, in_ready},  32'd1);
    check("stall_after_out_valid", {31'd0, out_valid}, 32'd0);

    // Reset in the 4th RUN cycle discards the operation.
    issue(16'h1357, 16'h2468);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_p",         p,                  32'd0);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_busy",      {31'd0, busy},      32'd0);
    check("midrst_in_ready",  {31'd0, in_ready},  32'd1);
    run_op("p_7x6", 16'd7, 16'd6, E_7X6);

    // Random operands with random backpressure and stray in_valid pulses.
    for (int n = 0; n < 1500; n++) begin
      case ($urandom_range(0, 7))
        0:       ra = 16'h8000;
        1:       ra = 16'h7FFF;
        2:       ra = 16'hFFFF;
        default: ra = 16'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0:       rb = 16'h8000;
        1:       rb = 16'h7FFF;
        2:       rb = 16'hFFFF;
        default: rb = 16'($urandom);
      endcase
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      out_ready = 1'($urandom_range(0, 1));
      issue(ra, rb);
      wait_out(1'b1, lat);
      guard = 0;
      while (guard < 50) begin
        out_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        guard++;
        if (out_ready) break;
      end
      if (guard >= 50) fail_now("rand_consume");
    end

    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #900000;
    n_cmp++;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
